// File: rtl/l2_tag_dir.sv
// l2_tag_dir: tag / MESI / tree-PLRU directory for an N-way set-associative L2.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_cmd              0 READ, 1 WRITE, 2 SNOOP_RD, 3 SNOOP_INV, 4-7 reserved
//   req_index, req_tag   set index and tag
//   req_snoop_hit        READ miss fills in S instead of E
//   resp_valid           one-cycle response pulse (UPDATE state)
//   resp_hit/resp_way    hit flag and hit or filled way
//   resp_mesi            line state after the operation
//   resp_evict*          a valid line was replaced: its dirtiness and tag
//   resp_hitm            snoop hit an M line
//
// A request spends one cycle in LOOKUP, where the set is compared and the full result
// is registered, and one cycle in UPDATE, where the response is presented and the
// array write commits.
module l2_tag_dir #(
    parameter int unsigned INDEX_BITS = 14,
    parameter int unsigned TAG_BITS   = 12,
    parameter int unsigned WAYS       = 8,
    parameter int unsigned WAY_BITS   = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_cmd,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [TAG_BITS-1:0]   req_tag,
    input  logic                  req_snoop_hit,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [WAY_BITS-1:0]   resp_way,
    output logic [1:0]            resp_mesi,
    output logic                  resp_evict,
    output logic                  resp_evict_dirty,
    output logic [TAG_BITS-1:0]   resp_evict_tag,
    output logic                  resp_hitm
);

    localparam int unsigned SETS = 1 << INDEX_BITS;

    localparam logic [1:0] MesiI = 2'd0;
    localparam logic [1:0] MesiS = 2'd1;
    localparam logic [1:0] MesiE = 2'd2;
    localparam logic [1:0] MesiM = 2'd3;

    localparam logic [2:0] CmdRead     = 3'd0;
    localparam logic [2:0] CmdWrite    = 3'd1;
    localparam logic [2:0] CmdSnoopRd  = 3'd2;
    localparam logic [2:0] CmdSnoopInv = 3'd3;

    typedef enum logic [1:0] {StInit, StIdle, StLookup, StUpdate} state_e;

    // Directory storage, one row per set.
    logic [WAYS-1:0][1:0]          mesi_arr_q [SETS];
    logic [WAYS-1:0][TAG_BITS-1:0] tag_arr_q  [SETS];
    logic [WAYS-2:0]               plru_arr_q [SETS];

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] cnt_q, cnt_d;
    logic [2:0]            req_cmd_q, req_cmd_d;
    logic [INDEX_BITS-1:0] req_idx_q, req_idx_d;
    logic [TAG_BITS-1:0]   req_tag_q, req_tag_d;
    logic                  req_snp_q, req_snp_d;

    // Pending array write, decided in LOOKUP and committed in UPDATE.
    logic                  wr_en_q, wr_en_d;
    logic [WAY_BITS-1:0]   wr_way_q, wr_way_d;
    logic [1:0]            wr_mesi_q, wr_mesi_d;
    logic                  touch_q, touch_d;

    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [WAY_BITS-1:0]   resp_way_q, resp_way_d;
    logic [1:0]            resp_mesi_q, resp_mesi_d;
    logic                  resp_evict_q, resp_evict_d;
    logic                  resp_dirty_q, resp_dirty_d;
    logic [TAG_BITS-1:0]   resp_etag_q, resp_etag_d;
    logic                  resp_hitm_q, resp_hitm_d;

    logic [WAYS-1:0][1:0]          row_mesi;
    logic [WAYS-1:0][TAG_BITS-1:0] row_tag;
    logic [WAYS-2:0]               row_plru;

    logic                  hit;
    logic [WAY_BITS-1:0]   hit_way;
    logic                  free_found;
    logic [WAY_BITS-1:0]   free_way;
    logic [WAY_BITS-1:0]   plru_way;
    logic [WAY_BITS-1:0]   victim;
    logic [WAYS-2:0]       plru_touched;

    logic                          arr_we, plru_we;
    logic [INDEX_BITS-1:0]         arr_idx;
    logic [WAYS-1:0][1:0]          mesi_row_d;
    logic [WAYS-1:0][TAG_BITS-1:0] tag_row_d;
    logic [WAYS-2:0]               plru_row_d;

    // Tree walk scratch (heap-ordered nodes, padded to WAYS bits for exact-width indexing).
    logic [WAYS-1:0]     vic_ext, tch_ext;
    logic [WAY_BITS-1:0] vic_node, tch_node, tch_way;
    logic                tch_bit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {INDEX_BITS{1'b1}}) state_d = StIdle;
            end
            StIdle:   if (req_valid) state_d = StLookup;
            StLookup: state_d = StUpdate;
            StUpdate: state_d = StIdle;
            default:  state_d = StInit;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = (state_q == StIdle);
    end

    // ---------------- Request latch ----------------
    always_comb begin
        req_cmd_d = req_cmd_q;
        req_idx_d = req_idx_q;
        req_tag_d = req_tag_q;
        req_snp_d = req_snp_q;
        if (state_q == StIdle && req_valid) begin
            req_cmd_d = req_cmd;
            req_idx_d = req_index;
            req_tag_d = req_tag;
            req_snp_d = req_snoop_hit;
        end
    end

    // ---------------- Lookup ----------------
    always_comb begin
        row_mesi = mesi_arr_q[req_idx_q];
        row_tag  = tag_arr_q[req_idx_q];
        row_plru = plru_arr_q[req_idx_q];
    end

    // Descending scans so the lowest matching way wins.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (row_mesi[w] != MesiI && row_tag[w] == req_tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (row_mesi[w] == MesiI) begin
                free_found = 1'b1;
                free_way   = WAY_BITS'(w);
            end
        end
    end

    // Node bit 0 points to the lower half, 1 to the upper half.
    always_comb begin
        vic_ext  = {1'b0, row_plru};
        vic_node = '0;
        plru_way = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            plru_way = (plru_way << 1) | WAY_BITS'(vic_ext[vic_node]);
            vic_node = (vic_node << 1) + WAY_BITS'(1) + WAY_BITS'(vic_ext[vic_node]);
        end
        victim = free_found ? free_way : plru_way;
    end

    always_comb begin
        tch_ext  = {1'b0, row_plru};
        tch_node = '0;
        tch_way  = wr_way_q;
        tch_bit  = 1'b0;
        for (int l = 0; l < WAY_BITS; l++) begin
            tch_bit           = tch_way[WAY_BITS-1];
            tch_ext[tch_node] = ~tch_bit;
            tch_node          = (tch_node << 1) + WAY_BITS'(1) + WAY_BITS'(tch_bit);
            tch_way           = tch_way << 1;
        end
        plru_touched = tch_ext[WAYS-2:0];
    end

    // ---------------- Operation decode (used in LOOKUP) ----------------
    always_comb begin
        resp_hit_d   = 1'b0;
        resp_way_d   = '0;
        resp_mesi_d  = MesiI;
        resp_evict_d = 1'b0;
        resp_dirty_d = 1'b0;
        resp_etag_d  = '0;
        resp_hitm_d  = 1'b0;
        wr_en_d      = 1'b0;
        wr_way_d     = hit_way;
        wr_mesi_d    = MesiI;
        touch_d      = 1'b0;
        case (req_cmd_q)
            CmdRead, CmdWrite: begin
                wr_en_d = 1'b1;
                touch_d = 1'b1;
                if (hit) begin
                    resp_hit_d = 1'b1;
                    wr_mesi_d  = (req_cmd_q == CmdWrite) ? MesiM : row_mesi[hit_way];
                end else begin
                    wr_way_d = victim;
                    if (req_cmd_q == CmdWrite) wr_mesi_d = MesiM;
                    else                       wr_mesi_d = req_snp_q ? MesiS : MesiE;
                    if (row_mesi[victim] != MesiI) begin
                        resp_evict_d = 1'b1;
                        resp_dirty_d = (row_mesi[victim] == MesiM);
                        resp_etag_d  = row_tag[victim];
                    end
                end
                resp_way_d  = wr_way_d;
                resp_mesi_d = wr_mesi_d;
            end
            CmdSnoopRd, CmdSnoopInv: begin
                if (hit) begin
                    resp_hit_d  = 1'b1;
                    resp_way_d  = hit_way;
                    resp_hitm_d = (row_mesi[hit_way] == MesiM);
                    wr_en_d     = 1'b1;
                    wr_mesi_d   = (req_cmd_q == CmdSnoopRd) ? MesiS : MesiI;
                    resp_mesi_d = wr_mesi_d;
                end
            end
            default: ;
        endcase
        resp_valid_d = (state_q == StLookup);
    end

    // ---------------- Array write selection ----------------
    always_comb begin
        arr_we     = 1'b0;
        plru_we    = 1'b0;
        arr_idx    = req_idx_q;
        mesi_row_d = row_mesi;
        tag_row_d  = row_tag;
        plru_row_d = row_plru;
        if (state_q == StInit) begin
            arr_we     = 1'b1;
            plru_we    = 1'b1;
            arr_idx    = cnt_q;
            mesi_row_d = '0;
            tag_row_d  = '0;
            plru_row_d = '0;
        end else if (state_q == StUpdate) begin
            arr_we               = wr_en_q;
            plru_we              = touch_q;
            mesi_row_d[wr_way_q] = wr_mesi_q;
            tag_row_d[wr_way_q]  = req_tag_q;
            plru_row_d           = plru_touched;
        end
        // A reset drops the in-flight update.
        if (rst) begin
            arr_we  = 1'b0;
            plru_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mesi_arr_q[arr_idx] <= mesi_row_d;
            tag_arr_q[arr_idx]  <= tag_row_d;
        end
        if (plru_we) plru_arr_q[arr_idx] <= plru_row_d;
    end

    // ---------------- Request, pending write and response registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req_cmd_q    <= '0;
            req_idx_q    <= '0;
            req_tag_q    <= '0;
            req_snp_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_way_q     <= '0;
            wr_mesi_q    <= MesiI;
            touch_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_mesi_q  <= MesiI;
            resp_evict_q <= 1'b0;
            resp_dirty_q <= 1'b0;
            resp_etag_q  <= '0;
            resp_hitm_q  <= 1'b0;
        end else begin
            req_cmd_q    <= req_cmd_d;
            req_idx_q    <= req_idx_d;
            req_tag_q    <= req_tag_d;
            req_snp_q    <= req_snp_d;
            resp_valid_q <= resp_valid_d;
            if (state_q == StLookup) begin
                wr_en_q      <= wr_en_d;
                wr_way_q     <= wr_way_d;
                wr_mesi_q    <= wr_mesi_d;
                touch_q      <= touch_d;
                resp_hit_q   <= resp_hit_d;
                resp_way_q   <= resp_way_d;
                resp_mesi_q  <= resp_mesi_d;
                resp_evict_q <= resp_evict_d;
                resp_dirty_q <= resp_dirty_d;
                resp_etag_q  <= resp_etag_d;
                resp_hitm_q  <= resp_hitm_d;
            end
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_hit         = resp_hit_q;
    assign resp_way         = resp_way_q;
    assign resp_mesi        = resp_mesi_q;
    assign resp_evict       = resp_evict_q;
    assign resp_evict_dirty = resp_dirty_q;
    assign resp_evict_tag   = resp_etag_q;
    assign resp_hitm        = resp_hitm_q;

endmodule

// File: tb/tb_l2_tag_dir.sv
// Bench for l2_tag_dir (INDEX_BITS=4, TAG_BITS=12, WAYS=4). Expected responses are
// pushed to a queue as each request is driven and popped when the response pulse arrives.
module tb_l2_tag_dir;

    localparam logic [1:0] I = 2'd0;
    localparam logic [1:0] S = 2'd1;
    localparam logic [1:0] E = 2'd2;
    localparam logic [1:0] M = 2'd3;

    typedef struct packed {
        logic        hit;
        logic [1:0]  way;
        logic [1:0]  mesi;
        logic        evict;
        logic        dirty;
        logic [11:0] etag;
        logic        hitm;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_cmd = '0;
    logic [3:0]  req_index = '0;
    logic [11:0] req_tag = '0;
    logic        req_snoop_hit = 1'b0;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic [1:0]  resp_mesi;
    logic        resp_evict;
    logic        resp_evict_dirty;
    logic [11:0] resp_evict_tag;
    logic        resp_hitm;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t exp_q[$];

    always #5 clk = ~clk;

    l2_tag_dir #(
        .INDEX_BITS(4),
        .TAG_BITS  (12),
        .WAYS      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cmd         (req_cmd),
        .req_index       (req_index),
        .req_tag         (req_tag),
        .req_snoop_hit   (req_snoop_hit),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_way        (resp_way),
        .resp_mesi       (resp_mesi),
        .resp_evict      (resp_evict),
        .resp_evict_dirty(resp_evict_dirty),
        .resp_evict_tag  (resp_evict_tag),
        .resp_hitm       (resp_hitm)
    );

    function automatic resp_t mk(logic h, logic [1:0] w, logic [1:0] ms, logic ev,
                                 logic d, logic [11:0] et, logic hm);
        resp_t r;
        r = '{hit: h, way: w, mesi: ms, evict: ev, dirty: d, etag: et, hitm: hm};
        return r;
    endfunction

    function automatic string fmt(resp_t r);
        return $sformatf("hit=%0b way=%0d mesi=%0d evict=%0b dirty=%0b etag=%h hitm=%0b",
                         r.hit, r.way, r.mesi, r.evict, r.dirty, r.etag, r.hitm);
    endfunction

    function automatic resp_t sample();
        return mk(resp_hit, resp_way, resp_mesi, resp_evict, resp_evict_dirty,
                  resp_evict_tag, resp_hitm);
    endfunction

    // Drives one request and waits for its response; lat counts edges from the handshake
    // edge to the edge that raises resp_valid (99 when no response arrived).
    task automatic drive_req(input logic [2:0] cmd, input logic [3:0] idx,
                             input logic [11:0] tag, input logic snp,
                             output resp_t r, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid     = 1'b1;
        req_cmd       = cmd;
        req_index     = idx;
        req_tag       = tag;
        req_snoop_hit = snp;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = sample();
        if (!resp_valid) lat = 99;
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || sample() !== resp_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%0b valid=%0b %s, required ready=0 valid=0 all 0",
                     req_ready, resp_valid, fmt(sample()));
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready && n < 100);
        n_checks++;
        if (n != 16 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_length: got ready after %0d cycles, required 16", n);
        end
    endtask

    task automatic test_basic();
        resp_t r, e;
        int    lat;
        exp_q.push_back(mk(1'b0, 2'd0, E, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd0, 4'd0, 12'h111, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL read_miss_fill: got %s lat=%0d, required %s lat=2", fmt(r), lat, fmt(e));
        end
        // Single pulse; fields hold afterwards.
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || sample() !== e) begin
            n_fail++;
            $display("FAIL resp_pulse_hold: got valid=%0b %s, required valid=0 %s",
                     resp_valid, fmt(sample()), fmt(e));
        end
        exp_q.push_back(mk(1'b1, 2'd0, M, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd1, 4'd0, 12'h111, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL write_hit: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
        exp_q.push_back(mk(1'b1, 2'd0, S, 1'b0, 1'b0, 12'h0, 1'b1));
        drive_req(3'd2, 4'd0, 12'h111, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL snoop_rd_hitm: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
    endtask

    task automatic test_fill_evict();
        resp_t r, e;
        int    lat;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(1'b0, 2'(i), M, 1'b0, 1'b0, 12'h0, 1'b0));
            drive_req(3'd1, 4'd3, 12'hA00 + 12'(i), 1'b0, r, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e || lat != 2) begin
                n_fail++;
                $display("FAIL fill_way%0d: got %s lat=%0d, required %s", i, fmt(r), lat, fmt(e));
            end
        end
        exp_q.push_back(mk(1'b1, 2'd0, M, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd0, 4'd3, 12'hA00, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL read_hit_m: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
        exp_q.push_back(mk(1'b0, 2'd2, M, 1'b1, 1'b1, 12'hA02, 1'b0));
        drive_req(3'd1, 4'd3, 12'hB00, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL plru_evict: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
    endtask

    task automatic test_snoop_inv();
        resp_t r, e;
        int    lat;
        exp_q.push_back(mk(1'b1, 2'd1, I, 1'b0, 1'b0, 12'h0, 1'b1));
        drive_req(3'd3, 4'd3, 12'hA01, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL snoop_inv_hit: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
        exp_q.push_back(mk(1'b0, 2'd1, S, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd0, 4'd3, 12'hC00, 1'b1, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL refill_invalid_way: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
        exp_q.push_back(mk(1'b0, 2'd0, I, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd2, 4'd7, 12'h123, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL snoop_miss: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
    endtask

    task automatic test_reserved();
        resp_t r, e;
        int    lat;
        exp_q.push_back(mk(1'b0, 2'd0, I, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd5, 4'd3, 12'hC00, 1'b1, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL reserved_cmd: got %s lat=%0d, required %s lat=2", fmt(r), lat, fmt(e));
        end
        exp_q.push_back(mk(1'b1, 2'd1, S, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd0, 4'd3, 12'hC00, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL reserved_no_change: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
    endtask

    task automatic test_reset_mid_request();
        resp_t r, e;
        int    lat;
        int    n;
        logic  seen;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_cmd   = 3'd1;
        req_index = 4'd5;
        req_tag   = 12'h555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        seen      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin
                @(negedge clk);
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_request: got resp_valid=1, required no response");
        end
        exp_q.push_back(mk(1'b0, 2'd0, E, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd0, 4'd5, 12'h555, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL dropped_write_misses: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
        exp_q.push_back(mk(1'b0, 2'd0, E, 1'b0, 1'b0, 12'h0, 1'b0));
        drive_req(3'd0, 4'd3, 12'hA00, 1'b0, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e || lat != 2) begin
            n_fail++;
            $display("FAIL init_clears_set: got %s lat=%0d, required %s", fmt(r), lat, fmt(e));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_evict();
        test_snoop_inv();
        test_reserved();
        test_reset_mid_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
